// File: rtl/vend_pkg.sv
// vend_pkg: shared state encoding, default price table and select-width helper for vend_fsm
package vend_pkg;
  typedef enum logic [1:0] {IDLE, CREDIT, DISPENSE, CHANGE} state_t;
  localparam logic [31:0] DEF_PRICES = 32'h1E32_1428;
  function automatic int sel_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/vend_stock.sv
// vend_stock: per-item stock counters with vend decrement, bulk restock and empty flags
module vend_stock #(
  parameter int NUM_ITEMS = 4,
  parameter int STOCK_W = 4,
  parameter int INIT_STOCK = 5,
  parameter int SEL_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dec,
  input  logic [SEL_W-1:0]     item,
  input  logic                 restock,
  output logic [NUM_ITEMS-1:0] empty
);
  for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_cnt
    logic [STOCK_W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= STOCK_W'(INIT_STOCK);
      else if (restock) cnt <= STOCK_W'(INIT_STOCK);
      else if (dec && item == SEL_W'(i)) cnt <= cnt - STOCK_W'(1);
    assign empty[i] = cnt == '0;
  end
endmodule

// File: rtl/vend_fsm.sv
// vend_fsm: multi-item vending controller with credit, price/stock checks and dispense/change handshakes; define VEND_STOCK_EN for per-item stock
module vend_fsm
  import vend_pkg::*;
#(
  parameter int NUM_ITEMS = 4,
  parameter int CREDIT_W = 8,
  parameter int COIN_W = 4,
  parameter int MAX_CREDIT = 200,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = DEF_PRICES,
  parameter int STOCK_W = 4,
  parameter int INIT_STOCK = 5,
  localparam int SEL_W = sel_w(NUM_ITEMS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_valid,
  input  logic [COIN_W-1:0]   coin_value,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel_item,
  input  logic                cancel,
  input  logic                restock,
  output logic                disp_valid,
  output logic [SEL_W-1:0]    disp_item,
  input  logic                disp_ready,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amt,
  input  logic                change_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic                err_price,
  output logic                err_soldout,
  output logic                busy
);
  state_t state, state_n;
  logic [CREDIT_W-1:0] credit_n, price, change_amt_n;
  logic [CREDIT_W:0] sum;
  logic [NUM_ITEMS-1:0] empty;
  logic [SEL_W-1:0] disp_item_n;
  logic open, item_ok, soldout, do_cancel, sel_eff, sel_ok, coin_eff;
  logic disp_valid_n, change_valid_n, busy_n, coin_reject_n, err_price_n, err_soldout_n;

  assign open = state == IDLE || state == CREDIT;
  assign item_ok = {1'b0, sel_item} < (SEL_W+1)'(NUM_ITEMS);
  assign price = item_ok ? PRICES[int'(sel_item)*CREDIT_W +: CREDIT_W] : '0;
  assign soldout = item_ok && empty[sel_item];
  assign sum = {1'b0, credit} + (CREDIT_W+1)'(coin_value);
  // cancel outranks selection, which outranks a coin in the same cycle
  assign do_cancel = cancel && state == CREDIT;
  assign sel_eff = sel_valid && open && !do_cancel;
  assign sel_ok = sel_eff && state == CREDIT && item_ok && !soldout && credit >= price;
  assign coin_eff = coin_valid && open && !do_cancel && !sel_eff && sum <= (CREDIT_W+1)'(MAX_CREDIT);

`ifdef VEND_STOCK_EN
  vend_stock #(
    .NUM_ITEMS(NUM_ITEMS), .STOCK_W(STOCK_W), .INIT_STOCK(INIT_STOCK), .SEL_W(SEL_W)
  ) u_stock (
    .clk(clk), .rst_n(rst_n), .dec(sel_ok), .item(sel_item),
    .restock(restock && state == IDLE), .empty(empty)
  );
`else
  logic unused_restock;
  assign empty = '0;
  assign unused_restock = restock | (|STOCK_W'(INIT_STOCK));
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      credit <= '0;
      disp_valid <= 1'b0;
      disp_item <= '0;
      change_valid <= 1'b0;
      change_amt <= '0;
      coin_reject <= 1'b0;
      err_price <= 1'b0;
      err_soldout <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      credit <= credit_n;
      disp_valid <= disp_valid_n;
      disp_item <= disp_item_n;
      change_valid <= change_valid_n;
      change_amt <= change_amt_n;
      coin_reject <= coin_reject_n;
      err_price <= err_price_n;
      err_soldout <= err_soldout_n;
      busy <= busy_n;
    end

  always_comb begin
    case (state)
      IDLE, CREDIT: state_n = do_cancel ? CHANGE : sel_ok ? DISPENSE : coin_eff ? CREDIT : state;
      DISPENSE:     state_n = !disp_ready ? DISPENSE : credit != '0 ? CHANGE : IDLE;
      CHANGE:       state_n = change_ready ? IDLE : CHANGE;
      default:      state_n = IDLE;
    endcase
    credit_n = sel_ok ? credit - price : coin_eff ? sum[CREDIT_W-1:0] :
               (state == CHANGE && change_ready) ? '0 : credit;
  end

  always_comb begin
    disp_valid_n = state_n == DISPENSE;
    change_valid_n = state_n == CHANGE;
    busy_n = disp_valid_n || change_valid_n;
    disp_item_n = sel_ok ? sel_item : disp_item;
    change_amt_n = change_valid_n ? credit_n : '0;
    coin_reject_n = coin_valid && !coin_eff;
    err_price_n = sel_eff && (state == IDLE || !item_ok || (!soldout && credit < price));
    err_soldout_n = sel_eff && state == CREDIT && soldout;
  end
endmodule

// File: tb/tb_vend_fsm.sv
// tb_vend_fsm: scoreboard bench for vend_fsm with a transaction-level credit/stock model
module tb_vend_fsm;
  localparam int N = 4;
  localparam int MAXC = 200;
  localparam int INIT = 5;
  localparam int EV_REJ = 0, EV_ERRP = 1, EV_ERRS = 2, EV_DISP = 3, EV_CHG = 4;
  typedef struct {int kind; int val;} ev_t;

  logic clk = 0, rst_n = 1;
  logic coin_valid = 0, sel_valid = 0, cancel = 0, restock = 0;
  logic disp_ready = 0, change_ready = 0;
  logic [3:0] coin_value = 0;
  logic [1:0] sel_item = 0;
  logic disp_valid, change_valid, coin_reject, err_price, err_soldout, busy;
  logic [1:0] disp_item;
  logic [7:0] change_amt, credit;

  int checks = 0, fails = 0;
  ev_t exp_q[$];
  int m_credit = 0;
  int m_stock[N];
  int price[N] = '{40, 20, 50, 30};
  int dmode = 0, cmode = 0;
  string names[5] = '{"coin_reject", "err_price", "err_soldout", "dispense", "change"};

  vend_fsm dut (
    .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin_value(coin_value),
    .sel_valid(sel_valid), .sel_item(sel_item), .cancel(cancel), .restock(restock),
    .disp_valid(disp_valid), .disp_item(disp_item), .disp_ready(disp_ready),
    .change_valid(change_valid), .change_amt(change_amt), .change_ready(change_ready),
    .credit(credit), .coin_reject(coin_reject), .err_price(err_price),
    .err_soldout(err_soldout), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ready mode: 0 random, 1 always high, 2 always low
  initial forever begin
    @(posedge clk); #1;
    disp_ready = dmode == 1 ? 1'b1 : dmode == 2 ? 1'b0 : ($urandom_range(0, 2) != 0);
    change_ready = cmode == 1 ? 1'b1 : cmode == 2 ? 1'b0 : ($urandom_range(0, 2) != 0);
  end

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic seen(int kind, int val);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      fails++;
      $display("FAIL unexpected %s: got value %0d, expected no event", names[kind], val);
      return;
    end
    e = exp_q.pop_front();
    check({"event kind at ", names[kind]}, kind, e.kind);
    check({"event value of ", names[kind]}, val, e.val);
  endtask

  task automatic push(int k, int v);
    ev_t e;
    e.kind = k;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_credit = 0;
    foreach (m_stock[i]) m_stock[i] = INIT;
  endtask

  // monitor: every observed output event is matched against the scoreboard
  logic pd = 0, pc = 0;
  logic [1:0] pitem = 0;
  logic [7:0] pamt = 0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      pd = 0;
      pc = 0;
    end else begin
      if (pd) begin
        check("disp_valid held", disp_valid, 1);
        check("disp_item held", disp_item, pitem);
      end
      if (pc) begin
        check("change_valid held", change_valid, 1);
        check("change_amt held", change_amt, pamt);
      end
      if (coin_reject) seen(EV_REJ, 0);
      if (err_price) seen(EV_ERRP, 0);
      if (err_soldout) seen(EV_ERRS, 0);
      if (disp_valid && disp_ready) seen(EV_DISP, disp_item);
      if (change_valid && change_ready) seen(EV_CHG, change_amt);
      pd = disp_valid && !disp_ready;
      pitem = disp_item;
      pc = change_valid && !change_ready;
      pamt = change_amt;
    end
  end

  // model works on settled machine: credit > 0 means a credit is held
  task automatic issue(bit c, bit s, int item, bit v, int val);
    bit in_cr, ce, se;
    in_cr = m_credit > 0;
    ce = c && in_cr;
    se = s && !ce;
    if (v) begin
      if (ce || se || m_credit + val > MAXC) push(EV_REJ, 0);
      else m_credit += val;
    end
    if (se) begin
      if (!in_cr) push(EV_ERRP, 0);
      else if (m_stock[item] == 0) push(EV_ERRS, 0);
      else if (m_credit < price[item]) push(EV_ERRP, 0);
      else begin
        m_credit -= price[item];
`ifdef VEND_STOCK_EN
        m_stock[item]--;
`endif
        push(EV_DISP, item);
        if (m_credit > 0) push(EV_CHG, m_credit);
        m_credit = 0;
      end
    end
    if (ce) begin
      push(EV_CHG, m_credit);
      m_credit = 0;
    end
    cancel = c;
    sel_valid = s;
    sel_item = 2'(item);
    coin_valid = v;
    coin_value = 4'(val);
    @(posedge clk); #1;
    cancel = 0;
    sel_valid = 0;
    coin_valid = 0;
  endtask

  task automatic do_restock();
`ifdef VEND_STOCK_EN
    if (m_credit == 0) foreach (m_stock[i]) m_stock[i] = INIT;
`endif
    restock = 1;
    @(posedge clk); #1;
    restock = 0;
  endtask

  task automatic settle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("settle within 200 cycles", int'(n < 200), 1);
    check("credit", credit, m_credit);
  endtask

  initial begin
    int r, n;
    model_reset();
    #2 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    check("reset disp_valid", disp_valid, 0);
    check("reset disp_item", disp_item, 0);
    check("reset change_valid", change_valid, 0);
    check("reset change_amt", change_amt, 0);
    check("reset credit", credit, 0);
    check("reset coin_reject", coin_reject, 0);
    check("reset err_price", err_price, 0);
    check("reset err_soldout", err_soldout, 0);
    check("reset busy", busy, 0);

    dmode = 1; cmode = 1;
    repeat (4) issue(0, 0, 0, 1, 10);
    check("credit after 4x10", credit, 40);
    issue(0, 1, 0, 0, 0);
    settle();

    issue(0, 0, 0, 1, 15);
    issue(0, 0, 0, 1, 15);
    cmode = 2;
    issue(0, 1, 1, 0, 0);
    repeat (5) begin @(posedge clk); #1; end
    check("change_valid while hopper stalls", change_valid, 1);
    check("change_amt while hopper stalls", change_amt, 10);
    cmode = 1;
    settle();

    repeat (12) issue(0, 0, 0, 1, 15);
    issue(0, 0, 0, 1, 10);
    check("credit at 190", credit, 190);
    issue(0, 0, 0, 1, 15);
    settle();
    issue(1, 0, 0, 0, 0);
    settle();

    issue(0, 0, 0, 1, 10);
    issue(0, 1, 2, 0, 0);
    settle();
    issue(1, 0, 0, 0, 0);
    settle();

    issue(0, 0, 0, 1, 10);
    issue(0, 0, 0, 1, 10);
    issue(1, 1, 1, 1, 5);
    settle();

`ifdef VEND_STOCK_EN
    repeat (6) begin
      issue(0, 0, 0, 1, 15);
      issue(0, 0, 0, 1, 15);
      issue(0, 1, 3, 0, 0);
      settle();
    end
    issue(1, 0, 0, 0, 0);
    settle();
    do_restock();
    issue(0, 0, 0, 1, 15);
    issue(0, 0, 0, 1, 15);
    issue(0, 1, 3, 0, 0);
    settle();
`endif

    dmode = 0; cmode = 0;
    for (int t = 0; t < 400; t++) begin
      r = $urandom_range(0, 99);
      if (r < 55) begin
        issue(0, 0, 0, 1, $urandom_range(1, 15));
        if ($urandom_range(0, 2) == 0) settle();
      end else if (r < 80) begin
        issue(0, 1, $urandom_range(0, N-1), 0, 0);
        settle();
      end else if (r < 88) begin
        issue(1, 0, 0, 0, 0);
        settle();
      end else if (r < 95) begin
        issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, N-1),
              1'($urandom_range(0, 1)), $urandom_range(1, 15));
        settle();
      end else begin
        do_restock();
        settle();
      end
    end
    settle();

    // asynchronous reset while a dispense is pending
    dmode = 2;
    repeat (4) issue(0, 0, 0, 1, 10);
    issue(0, 1, 0, 0, 0);
    n = 0;
    while (!disp_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("disp_valid before reset", disp_valid, 1);
    @(negedge clk); #3;
    rst_n = 0;
    #1;
    check("async reset disp_valid", disp_valid, 0);
    check("async reset change_valid", change_valid, 0);
    check("async reset credit", credit, 0);
    check("async reset busy", busy, 0);
    check("async reset disp_item", disp_item, 0);
    exp_q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    dmode = 0;
    issue(0, 0, 0, 1, 7);
    issue(1, 0, 0, 0, 0);
    settle();

    repeat (3) @(posedge clk);
    check("scoreboard drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
